// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and serialises it
// as start + 8 data (LSB first) + optional parity + 1..2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          wrap, last_stop;

  assign wrap      = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (bit_q == 3'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    // The baud counter only runs while a bit is on the line.
    if (state_q inside {S_START, S_DATA, S_PAR, S_STOP})
      baud_d = wrap ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE:  if (tx_en && !fifo_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo_data;
        par_d   = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: if (wrap) state_d = S_DATA;
      S_DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: if (wrap) state_d = S_STOP;
      S_STOP: if (wrap) begin
        if (last_stop) begin
          bit_d   = '0;
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    busy    = 1'b1;
    fifo_re = 1'b0;
    tx_done = 1'b0;
    case (state_q)
      S_IDLE:  busy    = 1'b0;
      S_FETCH: fifo_re = 1'b1;
      S_START: tx      = 1'b0;
      S_DATA:  tx      = shift_q[0];
      S_PAR:   tx      = par_q;
      S_STOP:  tx_done = wrap && last_stop;
      default: ;
    endcase
  end
endmodule
